// File: rtl/stall_ctrl.sv
// -----------------------------------------------------------------------------
// stall_ctrl: hazard and stall controller for the 5-stage MIPS pipeline.
//
// Keeps a shadow copy of the destination register, write enable and Tnew of
// the instructions sitting in E and M. These are compared against the D-stage
// Tuse values to decide when D must be held and a bubble sent into E. It also
// owns the mult/div busy counter and holds HI/LO users in D while it runs.
//
// Ports:
//   CLK         rising-edge clock
//   reset       asynchronous active-low reset
//   rs_D, rt_D  D-stage source register fields
//   Tuse_rs_D   cycles until rs is consumed (3 = not used)
//   Tuse_rt_D   cycles until rt is consumed (3 = not used)
//   A3_D        D-stage destination register
//   RegWrite_D  D-stage instruction writes a GPR
//   Tnew_D      Tnew of the D instruction once it reaches E
//   md_op_D     00 none, 01 mult, 10 div, 11 treated as none
//   md_use_D    D instruction touches the mult/div unit or HI/LO
//   stall       hold PC and IF/ID
//   flush_E     clear ID/EX this edge (same as stall)
//   md_start    one-cycle start pulse to the mult/div unit
//   md_busy     mult/div counter non-zero
// -----------------------------------------------------------------------------
module stall_ctrl #(
   parameter int unsigned MULT_CYCLES = 5,
   parameter int unsigned DIV_CYCLES  = 10,
   parameter int unsigned CNT_W       = 4
) (
   input  logic       CLK,
   input  logic       reset,
   input  logic [4:0] rs_D,
   input  logic [4:0] rt_D,
   input  logic [1:0] Tuse_rs_D,
   input  logic [1:0] Tuse_rt_D,
   input  logic [4:0] A3_D,
   input  logic       RegWrite_D,
   input  logic [1:0] Tnew_D,
   input  logic [1:0] md_op_D,
   input  logic       md_use_D,
   output logic       stall,
   output logic       flush_E,
   output logic       md_start,
   output logic       md_busy
);

   // Shadow scoreboard for E and M
   logic [4:0]       a3_e_q, a3_m_q;
   logic             we_e_q, we_m_q;
   logic [1:0]       tnew_e_q, tnew_m_q;
   logic [1:0]       md_op_e_q;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   logic [1:0]       md_op_norm;
   logic [1:0]       tnew_m_d;
   logic             haz_rs, haz_rt, haz_md;

   // Opcode 11 is reserved and behaves as "no operation"
   assign md_op_norm = (md_op_D == 2'b11) ? 2'b00 : md_op_D;

   // A source stalls only if a producer in E or M will not have its value
   // ready by the time D's instruction consumes it.
   always_comb begin
      haz_rs = 1'b0;
      haz_rt = 1'b0;
      if (rs_D != 5'd0 && Tuse_rs_D != 2'd3) begin
         haz_rs = (rs_D == a3_e_q && we_e_q && tnew_e_q > Tuse_rs_D) ||
                  (rs_D == a3_m_q && we_m_q && tnew_m_q > Tuse_rs_D);
      end
      if (rt_D != 5'd0 && Tuse_rt_D != 2'd3) begin
         haz_rt = (rt_D == a3_e_q && we_e_q && tnew_e_q > Tuse_rt_D) ||
                  (rt_D == a3_m_q && we_m_q && tnew_m_q > Tuse_rt_D);
      end
   end

   assign haz_md   = md_use_D && (md_op_e_q != 2'b00 || cnt_q != '0);
   assign stall    = haz_rs || haz_rt || haz_md;
   assign flush_E  = stall;
   assign md_start = (md_op_e_q != 2'b00) && (cnt_q == '0);
   assign md_busy  = (cnt_q != '0);

   assign tnew_m_d = (tnew_e_q == 2'd0) ? 2'd0 : tnew_e_q - 2'd1;

   // A new op is only accepted with the counter idle; a forced op during a
   // count is ignored and the count keeps running down.
   always_comb begin
      cnt_d = cnt_q;
      if (md_start) begin
         cnt_d = (md_op_e_q == 2'b01) ? CNT_W'(MULT_CYCLES) : CNT_W'(DIV_CYCLES);
      end else if (cnt_q != '0) begin
         cnt_d = cnt_q - CNT_W'(1);
      end
   end

   always_ff @(posedge CLK or negedge reset) begin
      if (!reset) begin
         a3_e_q    <= 5'd0;
         we_e_q    <= 1'b0;
         tnew_e_q  <= 2'd0;
         md_op_e_q <= 2'b00;
         a3_m_q    <= 5'd0;
         we_m_q    <= 1'b0;
         tnew_m_q  <= 2'd0;
         cnt_q     <= '0;
      end else begin
         if (stall) begin
            a3_e_q    <= 5'd0;
            we_e_q    <= 1'b0;
            tnew_e_q  <= 2'd0;
            md_op_e_q <= 2'b00;
         end else begin
            a3_e_q    <= A3_D;
            we_e_q    <= RegWrite_D;
            tnew_e_q  <= Tnew_D;
            md_op_e_q <= md_op_norm;
         end
         a3_m_q   <= a3_e_q;
         we_m_q   <= we_e_q;
         tnew_m_q <= tnew_m_d;
         cnt_q    <= cnt_d;
      end
   end

endmodule

// File: tb/tb_stall_ctrl.sv
module tb_stall_ctrl;

   logic       CLK = 1'b0;
   logic       reset;
   logic [4:0] rs_D, rt_D, A3_D;
   logic [1:0] Tuse_rs_D, Tuse_rt_D, Tnew_D, md_op_D;
   logic       RegWrite_D, md_use_D;
   logic       stall, flush_E, md_start, md_busy;

   int n_vec = 0;
   int n_err = 0;

   stall_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10), .CNT_W(4)) dut (
      .CLK        (CLK),
      .reset      (reset),
      .rs_D       (rs_D),
      .rt_D       (rt_D),
      .Tuse_rs_D  (Tuse_rs_D),
      .Tuse_rt_D  (Tuse_rt_D),
      .A3_D       (A3_D),
      .RegWrite_D (RegWrite_D),
      .Tnew_D     (Tnew_D),
      .md_op_D    (md_op_D),
      .md_use_D   (md_use_D),
      .stall      (stall),
      .flush_E    (flush_E),
      .md_start   (md_start),
      .md_busy    (md_busy)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string name, input int act, input int exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s at %0t: got %0d, want %0d", name, $time, act, exp);
      end
   endtask

   // ---------------------------------------------------------------------------
   // Reference model: every issued instruction is remembered with the cycle it
   // entered E. Its remaining latency is Tnew minus its age; it is visible to
   // hazard checks only while its age is 0 (E) or 1 (M). The mult/div unit is
   // described by the cycle the op entered E and its busy length.
   // ---------------------------------------------------------------------------
   typedef struct {
      int dest;
      bit we;
      int tnew;
      int t;
   } ent_t;

   ent_t hist[$];
   int   cyc  = 0;
   int   md_t = -100;
   int   md_n = 0;

   function automatic bit m_data_haz(input int r, input int tuse);
      int age, rem;
      if (r == 0 || tuse == 3) return 1'b0;
      foreach (hist[i]) begin
         age = cyc - hist[i].t;
         if (age >= 0 && age <= 1) begin
            rem = hist[i].tnew - age;
            if (rem < 0) rem = 0;
            if (hist[i].we && hist[i].dest == r && rem > tuse) return 1'b1;
         end
      end
      return 1'b0;
   endfunction

   function automatic bit m_stall();
      bit md_h;
      md_h = md_use_D && (cyc >= md_t) && (cyc <= md_t + md_n);
      return m_data_haz(int'(rs_D), int'(Tuse_rs_D)) ||
             m_data_haz(int'(rt_D), int'(Tuse_rt_D)) || md_h;
   endfunction

   always @(posedge CLK or negedge reset) begin
      if (!reset) begin
         hist.delete();
         md_t = -100;
         md_n = 0;
      end else begin
         if (!m_stall()) begin
            hist.push_back('{dest: int'(A3_D), we: RegWrite_D, tnew: int'(Tnew_D), t: cyc + 1});
            if (md_op_D == 2'b01) begin md_t = cyc + 1; md_n = 5;  end
            if (md_op_D == 2'b10) begin md_t = cyc + 1; md_n = 10; end
         end
         while (hist.size() > 2) void'(hist.pop_front());
         cyc++;
      end
   end

   // Compare process: every cycle, away from the active edge
   always @(negedge CLK) begin
      bit es;
      es = reset ? m_stall() : 1'b0;
      chk("stall",    int'(stall),    int'(es));
      chk("flush_E",  int'(flush_E),  int'(es));
      chk("md_start", int'(md_start), int'(reset && cyc == md_t));
      chk("md_busy",  int'(md_busy),  int'(reset && cyc > md_t && cyc <= md_t + md_n));
   end

   // ---------------------------------------------------------------------------
   // Stimulus helpers
   // ---------------------------------------------------------------------------
   task automatic drive(input int rs, input int trs, input int rt, input int trt,
                        input int a3, input bit we, input int tnew,
                        input int mdop, input bit mduse);
      rs_D       = 5'(rs);
      Tuse_rs_D  = 2'(trs);
      rt_D       = 5'(rt);
      Tuse_rt_D  = 2'(trt);
      A3_D       = 5'(a3);
      RegWrite_D = we;
      Tnew_D     = 2'(tnew);
      md_op_D    = 2'(mdop);
      md_use_D   = mduse;
   endtask

   task automatic nop();
      drive(0, 3, 0, 3, 0, 1'b0, 0, 0, 1'b0);
   endtask

   task automatic next();
      @(posedge CLK);
      #1;
   endtask

   // mult/div in E followed by mflo in D; counts stall, start and busy cycles
   task automatic run_md(input int op, output int st, output int ms, output int mb);
      bit done;
      st = 0; ms = 0; mb = 0; done = 1'b0;
      drive(0, 3, 0, 3, 0, 1'b0, 0, op, 1'b1);
      next();
      drive(0, 3, 0, 3, 8, 1'b1, 0, 0, 1'b1);
      for (int i = 0; i < 30 && !done; i++) begin
         @(negedge CLK);
         st += int'(stall);
         ms += int'(md_start);
         mb += int'(md_busy);
         done = !stall;
         next();
      end
      if (!done) chk("md_timeout", 0, 1);
      nop();
   endtask

   int st, ms, mb;

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b0;
      nop();
      @(negedge CLK);
      chk("rst_stall", int'(stall), 0);
      chk("rst_busy",  int'(md_busy), 0);
      next();
      reset = 1'b1;
      @(negedge CLK);
      chk("post_rst_stall", int'(stall), 0);
      chk("post_rst_start", int'(md_start), 0);
      next();

      // lw $8 then addu using $8 in E: one stall cycle
      drive(0, 3, 0, 3, 8, 1'b1, 2, 0, 1'b0);
      next();
      drive(8, 1, 0, 3, 9, 1'b1, 1, 0, 1'b0);
      @(negedge CLK); chk("lw_addu_c1", int'(stall), 1);
      next();
      @(negedge CLK); chk("lw_addu_c2", int'(stall), 0);
      next(); nop(); repeat (3) next();

      // lw $8 then beq using $8 in D: two stall cycles
      drive(0, 3, 0, 3, 8, 1'b1, 2, 0, 1'b0);
      next();
      drive(8, 0, 0, 3, 0, 1'b0, 0, 0, 1'b0);
      @(negedge CLK); chk("lw_beq_c1", int'(stall), 1);
      next();
      @(negedge CLK); chk("lw_beq_c2", int'(stall), 1);
      next();
      @(negedge CLK); chk("lw_beq_c3", int'(stall), 0);
      next(); nop(); repeat (3) next();

      // lw $0 then reader of $0
      drive(0, 3, 0, 3, 0, 1'b1, 2, 0, 1'b0);
      next();
      drive(0, 0, 0, 0, 0, 1'b0, 0, 0, 1'b0);
      @(negedge CLK); chk("zero_reg", int'(stall), 0);
      next(); nop(); repeat (3) next();

      // lw $8 then instruction not using rt ($8 with Tuse 3)
      drive(0, 3, 0, 3, 8, 1'b1, 2, 0, 1'b0);
      next();
      drive(0, 3, 8, 3, 0, 1'b0, 0, 0, 1'b0);
      @(negedge CLK); chk("tuse3", int'(stall), 0);
      next(); nop(); repeat (3) next();

      // mult then mflo; div then mflo
      run_md(1, st, ms, mb);
      chk("mult_stall_cycles", st, 6);
      chk("mult_start_pulses", ms, 1);
      chk("mult_busy_cycles",  mb, 5);
      repeat (3) next();
      run_md(2, st, ms, mb);
      chk("div_stall_cycles", st, 11);
      chk("div_start_pulses", ms, 1);
      chk("div_busy_cycles",  mb, 10);
      repeat (3) next();

      // div followed by independent work: no stall, busy for 10 cycles
      drive(0, 3, 0, 3, 0, 1'b0, 0, 2, 1'b1);
      next();
      drive(9, 1, 10, 1, 11, 1'b1, 1, 0, 1'b0);
      st = 0; mb = 0;
      for (int i = 0; i < 14; i++) begin
         @(negedge CLK);
         st += int'(stall);
         mb += int'(md_busy);
         next();
      end
      chk("div_flow_stall", st, 0);
      chk("div_flow_busy",  mb, 10);
      nop(); repeat (3) next();

      // reset mid-count
      drive(0, 3, 0, 3, 0, 1'b0, 0, 2, 1'b1);
      next();
      drive(0, 3, 0, 3, 8, 1'b1, 0, 0, 1'b1);
      repeat (3) @(posedge CLK);
      #2;
      chk("pre_rst_busy",  int'(md_busy), 1);
      chk("pre_rst_stall", int'(stall), 1);
      #1 reset = 1'b0;
      #1;
      chk("async_rst_busy",  int'(md_busy), 0);
      chk("async_rst_stall", int'(stall), 0);
      next();
      reset = 1'b1;
      @(negedge CLK);
      chk("after_rst_mflo_stall", int'(stall), 0);
      chk("after_rst_start",      int'(md_start), 0);
      next(); nop(); repeat (2) next();

      // Randomized traffic, checked each cycle by the compare process
      for (int i = 0; i < 600; i++) begin
         int r, op;
         r  = $urandom_range(0, 31);
         op = (r == 0) ? 1 : (r == 1) ? 2 : (r == 2) ? 3 : 0;
         drive($urandom_range(0, 4), $urandom_range(0, 3),
               $urandom_range(0, 4), $urandom_range(0, 3),
               $urandom_range(0, 4), 1'($urandom_range(0, 1)), $urandom_range(0, 2),
               op, (op == 1 || op == 2) ? 1'b1 : ($urandom_range(0, 7) == 0));
         next();
      end

      nop();
      next();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
